// File: rtl/imm_enc_pkg.sv
// Shared definitions for the instruction encoder: format codes (matching the
// immediate generator's control encoding), common opcodes and the request record.
package imm_enc_pkg;

    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_S  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_J  = 3'b011;
    localparam logic [2:0] FMT_U  = 3'b100;
    localparam logic [2:0] FMT_SH = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  op;
    } enc_req_t;

    // True when bits [31:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
    function automatic logic sext_fits(logic [31:0] v, int unsigned msb);
        logic [31:0] t;
        t = $signed(v) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/imm_enc_fmt_chk.sv
// Combinational range/alignment check of an immediate against its target format.
module imm_fmt_chk
    import imm_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        err
);

    always_comb begin
        err = 1'b1;
        case (fmt)
            FMT_I, FMT_S: err = !sext_fits(imm, 11);
            FMT_B:        err = !sext_fits(imm, 12) || imm[0];
            FMT_J:        err = !sext_fits(imm, 20) || imm[0];
            FMT_U:        err = |imm[11:0];
            FMT_SH:       err = |imm[31:5];
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_enc.sv
// Two-stage valid/ready RISC-V instruction encoder: S1 captures the request and
// its representability check, S2 holds the packed instruction word.
module imm_enc
    import imm_enc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [31:0]      in_imm,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_f3,
    input  logic [6:0]       in_f7,
    input  logic [6:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ins,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic             s1_valid_reg;
    logic             s1_err_reg;
    enc_req_t         s1_req_reg;
    logic             s2_valid_reg;
    logic             s2_err_reg;
    logic [31:0]      s2_ins_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic             chk_err;
    logic             s1_adv;
    logic             s2_adv;
    logic [31:0]      asm_ins;
    logic [31:0]      s1_imm;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    imm_fmt_chk u_chk (
        .fmt (in_fmt),
        .imm (in_imm),
        .err (chk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_req_reg   <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_err_reg <= chk_err;
                s1_req_reg <= '{fmt: in_fmt, imm: in_imm, rd: in_rd, rs1: in_rs1,
                                rs2: in_rs2, f3: in_f3, f7: in_f7, op: in_op};
            end
        end
    end

    assign s1_imm = s1_req_reg.imm;

    // Out-of-range immediates are still packed from their low bits; illegal formats give zero.
    always_comb begin
        asm_ins = '0;
        case (s1_req_reg.fmt)
            FMT_I:  asm_ins = {s1_imm[11:0], s1_req_reg.rs1, s1_req_reg.f3,
                               s1_req_reg.rd, s1_req_reg.op};
            FMT_S:  asm_ins = {s1_imm[11:5], s1_req_reg.rs2, s1_req_reg.rs1,
                               s1_req_reg.f3, s1_imm[4:0], s1_req_reg.op};
            FMT_B:  asm_ins = {s1_imm[12], s1_imm[10:5], s1_req_reg.rs2, s1_req_reg.rs1,
                               s1_req_reg.f3, s1_imm[4:1], s1_imm[11], s1_req_reg.op};
            FMT_J:  asm_ins = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                               s1_req_reg.rd, s1_req_reg.op};
            FMT_U:  asm_ins = {s1_imm[31:12], s1_req_reg.rd, s1_req_reg.op};
            FMT_SH: asm_ins = {s1_req_reg.f7, s1_imm[4:0], s1_req_reg.rs1,
                               s1_req_reg.f3, s1_req_reg.rd, s1_req_reg.op};
            default: asm_ins = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_err_reg   <= 1'b0;
            s2_ins_reg   <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_err_reg <= s1_err_reg;
                s2_ins_reg <= asm_ins;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (s2_valid_reg && out_ready && s2_err_reg && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_ins   = s2_ins_reg;
    assign out_err   = s2_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
